// File: rtl/osd_stm_event_packetizer_pkg.sv
// Shared types and constants for the STM trace-event packetizer: DII flit,
// trace event record, packet FSM states and TYPE-flit encoding.
package osd_stm_event_packetizer_pkg;

  localparam logic [1:0] EV_TYPE_EVENT = 2'b10;
  localparam logic [3:0] STM_TRACE     = 4'h0;
  localparam logic [3:0] STM_OVERFLOW  = 4'h5;
  localparam int         MAX_VALWIDTH  = 64;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef struct packed {
    logic [31:0]             timestamp;
    logic [15:0]             id;
    logic [MAX_VALWIDTH-1:0] value;
  } stm_event_t;

  typedef enum logic [3:0] {
    IDLE, DEST, SRC, TYPE, TS_LO, TS_HI, EID, VAL, OVF_CNT
  } pkt_state_e;

  typedef enum logic {KIND_TRACE, KIND_OVERFLOW} pkt_kind_e;

  function automatic dii_flit mk_flit(input logic last, input logic [15:0] data);
    return '{valid: 1'b1, last: last, data: data};
  endfunction

  function automatic logic [15:0] type_word(input logic [3:0] subtype);
    return {EV_TYPE_EVENT, subtype, 10'h000};
  endfunction

endpackage

// File: rtl/osd_stm_event_packetizer_if.sv
// DII output link: one registered flit plus the downstream ready.
interface osd_stm_event_packetizer_if;
  import osd_stm_event_packetizer_pkg::*;

  dii_flit debug_out;
  logic    debug_out_ready;

  modport master (output debug_out, input debug_out_ready);
  modport slave  (input debug_out, output debug_out_ready);
endinterface

// File: rtl/osd_stm_event_packetizer_fifo.sv
// Parameterized synchronous FIFO with registered occupancy; head is
// presented combinationally on rd_data.
module osd_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/osd_stm_event_packetizer.sv
// Timestamps filtered STM trace events, buffers them and serializes each into a
// DII event packet; drops while overflowed and reports the drop count in-band.
module osd_stm_event_packetizer
  import osd_stm_event_packetizer_pkg::*;
#(
  parameter int VALWIDTH    = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 id,
  input  logic [15:0]                 event_dest,
  input  logic                        enable,
  input  logic                        trace_valid,
  input  logic [15:0]                 trace_id,
  input  logic [VALWIDTH-1:0]         trace_value,
  osd_stm_event_packetizer_if.master  dii,
  output logic [15:0]                 overflow_count
);
  localparam int         NCHUNK     = VALWIDTH / 16;
  localparam int         EW         = 48 + VALWIDTH;
  localparam logic [1:0] LAST_CHUNK = 2'(NCHUNK - 1);

  if ((VALWIDTH % 16) != 0 || VALWIDTH < 16 || VALWIDTH > MAX_VALWIDTH) begin : g_bad_valwidth
    $error("VALWIDTH must be a multiple of 16 in the range 16..64");
  end
  if (6 + NCHUNK > MAX_PKT_LEN) begin : g_bad_pkt_len
    $error("trace packet of 6 + VALWIDTH/16 flits exceeds MAX_PKT_LEN");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  pkt_state_e state_q, state_d;
  pkt_kind_e  kind_q, kind_d;
  logic [1:0] chunk_q, chunk_d, chunk_n;
  dii_flit    flit_q, flit_d;
  stm_event_t pkt_q;
  logic [31:0] timestamp;
  logic        ovf_lock;

  logic          fifo_full, fifo_empty, fifo_wr, pop, accept, start, ovf_ack, drop;
  logic [EW-1:0] fifo_rd;
  logic [MAX_VALWIDTH-1:0] val_shift;

  // Capture uses the registered full flag, so a pop in the same cycle does not free a slot.
  assign fifo_wr = enable && trace_valid && !fifo_full && !ovf_lock;
  assign drop    = enable && trace_valid && (fifo_full || ovf_lock);
  assign accept  = flit_q.valid && dii.debug_out_ready;
  assign dii.debug_out = flit_q;

  osd_fifo_sync #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({timestamp, trace_id, trace_value}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   ()
  );

  // NOTE: next-state logic uses blocking assignments with every output defaulted first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    chunk_d   = chunk_q;
    flit_d    = flit_q;
    pop       = 1'b0;
    start     = 1'b0;
    ovf_ack   = 1'b0;
    chunk_n   = chunk_q + 2'd1;
    val_shift = pkt_q.value >> {chunk_n, 4'b0000};

    unique case (state_q)
      IDLE:  start = 1'b1;
      DEST:  if (accept) begin state_d = SRC; flit_d = mk_flit(1'b0, id); end
      SRC:   if (accept) begin
               state_d = TYPE;
               flit_d  = mk_flit(1'b0, type_word(kind_q == KIND_OVERFLOW ? STM_OVERFLOW : STM_TRACE));
             end
      TYPE:  if (accept) begin
               if (kind_q == KIND_OVERFLOW) begin
                 state_d = OVF_CNT;
                 flit_d  = mk_flit(1'b1, overflow_count);
               end else begin
                 state_d = TS_LO;
                 flit_d  = mk_flit(1'b0, pkt_q.timestamp[15:0]);
               end
             end
      TS_LO: if (accept) begin state_d = TS_HI; flit_d = mk_flit(1'b0, pkt_q.timestamp[31:16]); end
      TS_HI: if (accept) begin state_d = EID; flit_d = mk_flit(1'b0, pkt_q.id); end
      EID:   if (accept) begin
               state_d = VAL;
               chunk_d = 2'd0;
               flit_d  = mk_flit(LAST_CHUNK == 2'd0, pkt_q.value[15:0]);
             end
      VAL:   if (accept) begin
               if (chunk_q == LAST_CHUNK) begin
                 start = 1'b1;
               end else begin
                 chunk_d = chunk_n;
                 flit_d  = mk_flit(chunk_n == LAST_CHUNK, val_shift[15:0]);
               end
             end
      OVF_CNT: if (accept) begin ovf_ack = 1'b1; state_d = IDLE; flit_d = '0; end
      default: begin state_d = IDLE; flit_d = '0; end
    endcase

    // Pending trace events drain before the overflow report to keep host-side ordering.
    if (start) begin
      if (ovf_lock && fifo_empty) begin
        state_d = DEST;
        kind_d  = KIND_OVERFLOW;
        flit_d  = mk_flit(1'b0, event_dest);
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = DEST;
        kind_d  = KIND_TRACE;
        flit_d  = mk_flit(1'b0, event_dest);
      end else begin
        state_d = IDLE;
        flit_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= KIND_TRACE;
      chunk_q <= '0;
      flit_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      chunk_q <= chunk_d;
      flit_q  <= flit_d;
      if (pop) begin
        pkt_q.timestamp <= fifo_rd[EW-1 -: 32];
        pkt_q.id        <= fifo_rd[VALWIDTH +: 16];
        pkt_q.value     <= MAX_VALWIDTH'(fifo_rd[VALWIDTH-1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timestamp      <= '0;
      overflow_count <= '0;
      ovf_lock       <= 1'b0;
    end else begin
      timestamp <= timestamp + 32'd1;
      if (ovf_ack) begin
        overflow_count <= drop ? 16'd1 : 16'd0;
        ovf_lock       <= drop;
      end else if (drop) begin
        if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        ovf_lock <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osd_stm_event_packetizer.sv
// Self-checking bench: expected flits are queued as events are driven and
// compared as the DUT hands each flit over.
module tb_osd_stm_event_packetizer;
  import osd_stm_event_packetizer_pkg::*;

  localparam int VW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   id_port = 16'h0005;
  logic [15:0]   event_dest = 16'h0000;
  logic          enable = 1'b1;
  logic          trace_valid = 1'b0;
  logic [15:0]   trace_id = '0;
  logic [VW-1:0] trace_value = '0;
  logic [15:0]   overflow_count;

  osd_stm_event_packetizer_if dii ();

  osd_stm_event_packetizer #(.VALWIDTH(VW), .FIFO_DEPTH(4), .MAX_PKT_LEN(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id             (id_port),
    .event_dest     (event_dest),
    .enable         (enable),
    .trace_valid    (trace_valid),
    .trace_id       (trace_id),
    .trace_value    (trace_value),
    .dii            (dii),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [31:0] tb_ts;

  typedef struct {
    logic        en;
    logic [15:0] eid;
    logic [31:0] val;
    int          gap;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference free-running timestamp.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  task automatic push_trace(input logic [31:0] ts, input logic [15:0] eid, input logic [31:0] val);
    exp_q.push_back({1'b0, event_dest});
    exp_q.push_back({1'b0, id_port});
    exp_q.push_back({1'b0, 16'h8000});
    exp_q.push_back({1'b0, ts[15:0]});
    exp_q.push_back({1'b0, ts[31:16]});
    exp_q.push_back({1'b0, eid});
    exp_q.push_back({1'b0, val[15:0]});
    exp_q.push_back({1'b1, val[31:16]});
  endtask

  task automatic push_ovf(input logic [15:0] cnt);
    exp_q.push_back({1'b0, event_dest});
    exp_q.push_back({1'b0, id_port});
    exp_q.push_back({1'b0, 16'h9400});
    exp_q.push_back({1'b1, cnt});
  endtask

  // Called just after a rising edge; the next edge samples the event.
  task automatic send_event(input logic [15:0] eid, input logic [31:0] val,
                            input logic en, input logic push);
    enable      = en;
    trace_valid = 1'b1;
    trace_id    = eid;
    trace_value = val;
    if (push) push_trace(tb_ts, eid, val);
    @(posedge clk); #1;
    trace_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Flit monitor: compares accepted flits and checks stability under backpressure.
  logic [17:0] prev_flit;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", dii.debug_out, prev_flit);
      if (dii.debug_out.valid && dii.debug_out_ready) begin
        check("flit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("flit", {dii.debug_out.last, dii.debug_out.data}, e);
        end
      end
      prev_stall = dii.debug_out.valid && !dii.debug_out_ready;
      prev_flit  = dii.debug_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 32'h0000_0000, 12};
    vecs[1] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 12};
    vecs[2] = '{1'b0, 16'h0111, 32'h0101_0101, 0};
    vecs[3] = '{1'b0, 16'h0222, 32'h0202_0202, 0};
    vecs[4] = '{1'b0, 16'h0333, 32'h0303_0303, 12};
    vecs[5] = '{1'b1, 16'h0C01, 32'hCAFE_F00D, 0};
    vecs[6] = '{1'b1, 16'h0C02, 32'h0BAD_C0DE, 0};
    vecs[7] = '{1'b1, 16'h0C03, 32'h1357_9BDF, 30};

    dii.debug_out_ready = 1'b1;
    #2;
    check("rst_valid", dii.debug_out.valid, 0);
    check("rst_last", dii.debug_out.last, 0);
    check("rst_data", dii.debug_out.data, 0);
    check("rst_ovf_count", overflow_count, 0);
    #30 rst_n = 1'b1;

    // Single event at timestamp 0x10 with latency check.
    while (tb_ts != 32'h10) begin @(posedge clk); #1; end
    trace_valid = 1'b1; trace_id = 16'h0001; trace_value = 32'hDEAD_BEEF;
    push_trace(tb_ts, 16'h0001, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    trace_valid = 1'b0;
    check("latency_t1_valid", dii.debug_out.valid, 0);
    @(posedge clk); #1;
    check("latency_t2_valid", dii.debug_out.valid, 1);
    wait_drain("drain_single", 40);

    // Backpressure: ready toggles every cycle during one packet.
    event_dest = 16'h00C3;
    dii.debug_out_ready = 1'b0;
    send_event(16'h0042, 32'hA5A5_5A5A, 1'b1, 1'b1);
    repeat (30) begin
      @(posedge clk); #1;
      dii.debug_out_ready = ~dii.debug_out_ready;
    end
    dii.debug_out_ready = 1'b1;
    wait_drain("drain_backpressure", 40);

    // Table-driven events, including disabled ones and a short burst.
    for (int i = 0; i < 8; i++) begin
      send_event(vecs[i].eid, vecs[i].val, vecs[i].en, vecs[i].en);
      repeat (vecs[i].gap) @(posedge clk);
      #1;
    end
    enable = 1'b1;
    wait_drain("drain_table", 80);
    check("table_ovf_count", overflow_count, 0);

    // Overflow: one packet stalled in flight, then 7 events into a 4-deep FIFO.
    dii.debug_out_ready = 1'b0;
    send_event(16'h0F00, 32'h0000_F000, 1'b1, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++)
      send_event(16'h0F01 + 16'(i), 32'h1000_0000 + 32'(i), 1'b1, i < 4);
    check("ovf_count_3", overflow_count, 3);
    dii.debug_out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send_event(16'h0FEE, 32'hEEEE_EEEE, 1'b1, 1'b0);
    check("ovf_count_locked", overflow_count, 4);
    push_ovf(16'd4);
    wait_drain("drain_overflow", 120);
    check("ovf_count_cleared", overflow_count, 0);

    // Timestamp wrap: FFFFFFFF then 00000000 on consecutive events.
    force dut.timestamp = 32'hFFFF_FFFF;
    send_event(16'h0A01, 32'h1111_2222, 1'b0, 1'b0);
    check("wrap_no_capture_while_disabled", overflow_count, 0);
    enable = 1'b1; trace_valid = 1'b1; trace_id = 16'h0A01; trace_value = 32'h1111_2222;
    push_trace(32'hFFFF_FFFF, 16'h0A01, 32'h1111_2222);
    @(posedge clk); #1;
    force dut.timestamp = 32'h0000_0000;
    trace_id = 16'h0A02; trace_value = 32'h3333_4444;
    push_trace(32'h0000_0000, 16'h0A02, 32'h3333_4444);
    @(posedge clk); #1;
    trace_valid = 1'b0;
    release dut.timestamp;
    wait_drain("drain_wrap", 60);

    // Reset after the TYPE flit, then a clean packet.
    send_event(16'h0B0B, 32'h7777_8888, 1'b1, 1'b1);
    begin
      int n = 0;
      while (exp_q.size() > 5 && n < 40) begin @(posedge clk); n++; end
      check("reset_reach_type", exp_q.size(), 5);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midpkt_rst_valid", dii.debug_out.valid, 0);
    check("midpkt_rst_last", dii.debug_out.last, 0);
    check("midpkt_rst_data", dii.debug_out.data, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", dii.debug_out.valid, 0);
    send_event(16'h0C0C, 32'h9999_AAAA, 1'b1, 1'b1);
    wait_drain("drain_after_reset", 40);
    check("post_rst_ovf_count", overflow_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
